// File: rtl/repeat_step_counter_pkg.sv
// Shared encodings for the repeat/step counter: step modes and bounce FSM states.
package repeat_step_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DN   = 2'b01,
        MODE_BNC  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_UP = 1'b0,
        ST_DN = 1'b1
    } state_e;

    // A mode of HOLD freezes the block exactly like a deasserted enable.
    function automatic logic mode_runs(input logic [1:0] mode);
        return mode != MODE_HOLD;
    endfunction

endpackage

// File: rtl/repeat_step_counter_dwell_prescaler.sv
// Dwell prescaler: counts enabled cycles 1..rpt_eff and flags the advance edge.
module dwell_prescaler #(
    parameter int RPT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [RPT_W-1:0] rpt,
    output logic             adv
);

    logic [RPT_W-1:0] dcnt;
    logic [RPT_W-1:0] rpt_eff;

    assign rpt_eff = (rpt == '0) ? RPT_W'(1) : rpt;
    // >= rather than == so that lowering rpt mid-dwell advances on the next enabled edge.
    assign adv     = en && !clr && (dcnt >= rpt_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt <= RPT_W'(1);
        end else if (clr || adv) begin
            dcnt <= RPT_W'(1);
        end else if (en) begin
            dcnt <= dcnt + RPT_W'(1);
        end
    end

endmodule

// File: rtl/repeat_step_counter.sv
// Counter that dwells rpt enabled cycles per value, stepping up, down or bouncing over 0..max_val.
module repeat_step_counter
    import repeat_step_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RPT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [RPT_W-1:0] rpt,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             step,
    output logic             wrap
);

    logic             en_eff;
    logic             adv;
    state_e           state;
    state_e           st_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;

    assign en_eff = en && mode_runs(mode);

    dwell_prescaler #(.RPT_W(RPT_W)) u_dwell (
        .clk (clk),
        .rst (rst),
        .en  (en_eff),
        .clr (clr),
        .rpt (rpt),
        .adv (adv)
    );

    // Next value if this edge advances; the -1 paths are only reached when the operand is non-zero.
    always_comb begin
        cnt_nxt  = cnt;
        st_nxt   = state;
        wrap_nxt = 1'b0;
        case (mode_e'(mode))
            MODE_UP: begin
                st_nxt = ST_UP;
                if (cnt >= max_val) begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end
            MODE_DN: begin
                st_nxt = ST_DN;
                if (cnt == '0) begin
                    cnt_nxt  = max_val;
                    wrap_nxt = 1'b1;
                end else if (cnt > max_val) begin
                    cnt_nxt = max_val;
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end
            MODE_BNC: begin
                if (state == ST_UP) begin
                    if (cnt >= max_val) begin
                        // A zero range pins cnt at 0 while the direction still flips.
                        cnt_nxt  = (max_val == '0) ? '0 : max_val - WIDTH'(1);
                        st_nxt   = ST_DN;
                        wrap_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + WIDTH'(1);
                    end
                end else begin
                    if (cnt == '0) begin
                        cnt_nxt  = (max_val == '0) ? '0 : WIDTH'(1);
                        st_nxt   = ST_UP;
                        wrap_nxt = 1'b1;
                    end else if (cnt > max_val) begin
                        cnt_nxt = max_val;
                    end else begin
                        cnt_nxt = cnt - WIDTH'(1);
                    end
                end
            end
            default: begin
                cnt_nxt  = cnt;
                st_nxt   = state;
                wrap_nxt = 1'b0;
            end
        endcase
    end

    // Pulses are refreshed only on enabled cycles, so they hold along with cnt while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            state <= ST_UP;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            state <= ST_UP;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else if (en_eff) begin
            step <= adv;
            wrap <= adv && wrap_nxt;
            if (adv) begin
                cnt   <= cnt_nxt;
                state <= st_nxt;
            end
        end
    end

    assign dir = (state == ST_UP);

endmodule

// File: tb/tb_repeat_step_counter.sv
// Directed, table-driven bench for repeat_step_counter (WIDTH=4, RPT_W=3).
module tb_repeat_step_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [2:0] rpt;
    logic [3:0] max_val;
    logic [3:0] cnt;
    logic       dir;
    logic       step;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       clr;
        logic [1:0] mode;
        logic [2:0] rpt;
        logic [3:0] mx;
        logic [3:0] cnt;
        logic       dir;
        logic       step;
        logic       wrap;
    } vec_t;

    vec_t vq[$];

    repeat_step_counter #(.WIDTH(4), .RPT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .mode    (mode),
        .rpt     (rpt),
        .max_val (max_val),
        .cnt     (cnt),
        .dir     (dir),
        .step    (step),
        .wrap    (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void addv(input int e, input int c, input int m, input int r, input int mx,
                                 input int ecnt, input int edir, input int estep, input int ewrap);
        vec_t v;
        v.en   = 1'(e);
        v.clr  = 1'(c);
        v.mode = 2'(m);
        v.rpt  = 3'(r);
        v.mx   = 4'(mx);
        v.cnt  = 4'(ecnt);
        v.dir  = 1'(edir);
        v.step = 1'(estep);
        v.wrap = 1'(ewrap);
        vq.push_back(v);
    endfunction

    // Apply each queued record for one clock edge and compare just after that edge.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            en      = vq[i].en;
            clr     = vq[i].clr;
            mode    = vq[i].mode;
            rpt     = vq[i].rpt;
            max_val = vq[i].mx;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].cnt", tag, i),  32'(cnt),  32'(vq[i].cnt));
            chk($sformatf("%s[%0d].dir", tag, i),  32'(dir),  32'(vq[i].dir));
            chk($sformatf("%s[%0d].step", tag, i), 32'(step), 32'(vq[i].step));
            chk($sformatf("%s[%0d].wrap", tag, i), 32'(wrap), 32'(vq[i].wrap));
        end
        vq.delete();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".cnt"},  32'(cnt),  32'd0);
        chk({tag, ".dir"},  32'(dir),  32'd1);
        chk({tag, ".step"}, 32'(step), 32'd0);
        chk({tag, ".wrap"}, 32'(wrap), 32'd0);
    endtask

    // Called just after a clock edge; reset is asserted and released between edges.
    task automatic do_reset(input string tag);
        en  = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        #2;
        chk_cleared(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00; rpt = 3'd1; max_val = 4'd0;
        #6;

        // Up-wrap, dwell 5, max 5: five of each value, wrap on the return to 0.
        do_reset("rst_a");
        for (int i = 1; i <= 31; i++)
            addv(1, 0, 0, 5, 5, (i / 5) % 6, 1, (i % 5 == 0) ? 1 : 0, (i == 30) ? 1 : 0);
        run_vecs("up_r5");

        // Bounce, dwell 1, max 3.
        do_reset("rst_b");
        addv(1,0,2,1,3, 1,1,1,0);
        addv(1,0,2,1,3, 2,1,1,0);
        addv(1,0,2,1,3, 3,1,1,0);
        addv(1,0,2,1,3, 2,0,1,1);
        addv(1,0,2,1,3, 1,0,1,0);
        addv(1,0,2,1,3, 0,0,1,0);
        addv(1,0,2,1,3, 1,1,1,1);
        addv(1,0,2,1,3, 2,1,1,0);
        run_vecs("bounce");

        // Down-wrap, dwell 2, max 4, then clear with en high and restart.
        do_reset("rst_c");
        addv(1,0,1,2,4, 0,1,0,0);
        addv(1,0,1,2,4, 4,0,1,1);
        addv(1,0,1,2,4, 4,0,0,0);
        addv(1,0,1,2,4, 3,0,1,0);
        addv(1,0,1,2,4, 3,0,0,0);
        addv(1,0,1,2,4, 2,0,1,0);
        addv(1,0,1,2,4, 2,0,0,0);
        addv(1,0,1,2,4, 1,0,1,0);
        addv(1,0,1,2,4, 1,0,0,0);
        addv(1,0,1,2,4, 0,0,1,0);
        addv(1,0,1,2,4, 0,0,0,0);
        addv(1,0,1,2,4, 4,0,1,1);
        addv(1,1,1,2,4, 0,1,0,0);
        addv(1,0,1,2,4, 0,1,0,0);
        addv(1,0,1,2,4, 4,0,1,1);
        run_vecs("down_clr");

        // rpt=0 and rpt=1 give the same sequence.
        for (int r = 0; r < 2; r++) begin
            do_reset("rst_d");
            addv(1,0,0,r,2, 1,1,1,0);
            addv(1,0,0,r,2, 2,1,1,0);
            addv(1,0,0,r,2, 0,1,1,1);
            addv(1,0,0,r,2, 1,1,1,0);
            run_vecs($sformatf("rpt%0d", r));
        end

        // Lower rpt 5->2 with dcnt at 4: advance on the next enabled edge.
        do_reset("rst_e");
        addv(1,0,0,5,7, 0,1,0,0);
        addv(1,0,0,5,7, 0,1,0,0);
        addv(1,0,0,5,7, 0,1,0,0);
        addv(1,0,0,2,7, 1,1,1,0);
        addv(1,0,0,2,7, 1,1,0,0);
        addv(1,0,0,2,7, 2,1,1,0);
        run_vecs("rpt_lower");

        // Enable gaps and mode HOLD: only enabled cycles count; outputs hold while frozen.
        do_reset("rst_f");
        addv(1,0,0,3,7, 0,1,0,0);
        addv(0,0,0,3,7, 0,1,0,0);
        addv(1,0,0,3,7, 0,1,0,0);
        addv(0,0,0,3,7, 0,1,0,0);
        addv(1,0,0,3,7, 1,1,1,0);
        addv(0,0,0,3,7, 1,1,1,0);
        addv(1,0,3,3,7, 1,1,1,0);
        addv(1,0,0,3,7, 1,1,0,0);
        addv(1,0,0,3,7, 1,1,0,0);
        addv(1,0,0,3,7, 2,1,1,0);
        run_vecs("en_gap");

        // max 9->3 at cnt=7: up wraps to 0, down clamps to 3 without wrap.
        for (int m = 0; m < 2; m++) begin
            do_reset("rst_g");
            for (int i = 1; i <= 7; i++) addv(1,0,0,1,9, i,1,1,0);
            if (m == 0) begin
                addv(1,0,0,1,3, 0,1,1,1);
                addv(1,0,0,1,3, 1,1,1,0);
            end else begin
                addv(1,0,1,1,3, 3,0,1,0);
                addv(1,0,1,1,3, 2,0,1,0);
            end
            run_vecs($sformatf("max_drop_m%0d", m));
        end

        // Bounce with max 0: cnt pinned at 0, wrap every advance, direction toggles.
        do_reset("rst_h");
        addv(1,0,2,1,0, 0,0,1,1);
        addv(1,0,2,1,0, 0,1,1,1);
        addv(1,0,2,1,0, 0,0,1,1);
        run_vecs("bnc_max0");

        // Async reset between edges while step is high, then a full dwell before the first step.
        do_reset("rst_i");
        addv(1,0,0,3,5, 0,1,0,0);
        addv(1,0,0,3,5, 0,1,0,0);
        addv(1,0,0,3,5, 1,1,1,0);
        run_vecs("pre_async");
        #2;
        rst = 1'b1;
        #1;
        chk_cleared("async_rst");
        #1;
        rst = 1'b0;
        addv(1,0,0,3,5, 0,1,0,0);
        addv(1,0,0,3,5, 0,1,0,0);
        addv(1,0,0,3,5, 1,1,1,0);
        run_vecs("post_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
